// File: rtl/cnt_seq_ctrl.sv
// ============================================================================
// cnt_seq_ctrl : pass/repeat sequencer driving a loadable 4-bit up/down counter
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_seq_ctrl #(
   parameter int W     = 4,
   parameter int DIV_W = 8,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             abort,
   input  logic             cfg_up,
   input  logic [W-1:0]     cfg_start,
   input  logic [W-1:0]     cfg_end,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [REP_W-1:0] cfg_reps,
   input  logic [W-1:0]     cnt_Q,
   output logic             cnt_ce,
   output logic             cnt_up,
   output logic [W-1:0]     cnt_di,
   output logic             cnt_L,
   output logic             busy,
   output logic             done,
   output logic [REP_W-1:0] pass_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);
   localparam logic [REP_W-1:0] C_REP_ONE = REP_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic [DIV_W-1:0] r_presc;
   logic [REP_W-1:0] r_pass;
   logic [REP_W-1:0] r_reps_left;
   logic             r_up;
   logic [W-1:0]     r_start;
   logic [W-1:0]     r_end;
   logic [DIV_W-1:0] r_div;

   logic w_tick;
   logic w_at_end;
   logic w_abort;

   assign w_tick   = (r_state == S_RUN) && (r_presc == r_div);
   assign w_at_end = (cnt_Q == r_end);
   assign w_abort  = abort && (r_state != S_IDLE);

   assign cnt_up   = r_up;
   assign cnt_di   = r_start;
   assign pass_cnt = r_pass;

   always_ff @(posedge clk) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      cnt_ce = 1'b0;
      cnt_L  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: if (start && !abort) w_next = S_LOAD;
         S_LOAD: begin
            cnt_L  = 1'b1;
            busy   = 1'b1;
            w_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            // abort suppresses the step even on a tick cycle
            cnt_ce = w_tick && !w_at_end && !abort;
            if (w_tick && w_at_end)
               w_next = (r_reps_left == '0) ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_presc     <= '0;
         r_pass      <= '0;
         r_reps_left <= '0;
         r_up        <= 1'b0;
         r_start     <= '0;
         r_end       <= '0;
         r_div       <= '0;
      end else if (!w_abort) begin
         case (r_state)
            S_IDLE: if (start && !abort) begin
               r_up        <= cfg_up;
               r_start     <= cfg_start;
               r_end       <= cfg_end;
               r_div       <= cfg_div;
               r_reps_left <= cfg_reps;
               r_pass      <= '0;
            end
            S_LOAD: r_presc <= '0;
            S_RUN: begin
               if (w_tick) begin
                  r_presc <= '0;
                  if (w_at_end) begin
                     if (r_pass != '1)         r_pass      <= r_pass + C_REP_ONE;
                     if (r_reps_left != '0)    r_reps_left <= r_reps_left - C_REP_ONE;
                  end
               end else begin
                  r_presc <= r_presc + C_DIV_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cnt_seq_ctrl.sv
// ============================================================================
// tb_cnt_seq_ctrl : scoreboard bench for cnt_seq_ctrl with a behavioural counter
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_seq_ctrl;
   localparam int W     = 4;
   localparam int DIV_W = 8;
   localparam int REP_W = 4;
   localparam int MODV  = 1 << W;

   logic             clk = 1'b0;
   logic             clr = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             cfg_up = 1'b0;
   logic [W-1:0]     cfg_start = '0;
   logic [W-1:0]     cfg_end = '0;
   logic [DIV_W-1:0] cfg_div = '0;
   logic [REP_W-1:0] cfg_reps = '0;
   logic [W-1:0]     cnt_Q;
   logic             cnt_ce, cnt_up, cnt_L, busy, done;
   logic [W-1:0]     cnt_di;
   logic [REP_W-1:0] pass_cnt;

   cnt_seq_ctrl #(.W(W), .DIV_W(DIV_W), .REP_W(REP_W)) dut (
      .clk(clk), .clr(clr), .start(start), .abort(abort),
      .cfg_up(cfg_up), .cfg_start(cfg_start), .cfg_end(cfg_end),
      .cfg_div(cfg_div), .cfg_reps(cfg_reps), .cnt_Q(cnt_Q),
      .cnt_ce(cnt_ce), .cnt_up(cnt_up), .cnt_di(cnt_di), .cnt_L(cnt_L),
      .busy(busy), .done(done), .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   // the counter being sequenced: load has priority over enable
   logic [W-1:0] q = '0;
   always @(posedge clk) begin
      if (cnt_L)       q <= cnt_di;
      else if (cnt_ce) q <= cnt_up ? q + 4'd1 : q - 4'd1;
   end
   assign cnt_Q = q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;   // 0 = load {up,di}, 1 = step (Q before step), 2 = done (pass_cnt)
      int cyc;
      int val;
   } ev_t;
   ev_t expq[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic see(input int kind, input int val);
      ev_t e;
      total++;
      if (expq.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: kind %0d val %0d at cycle %0d, none expected", kind, val, cyc);
      end else begin
         e = expq.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            bad++;
            $display("FAIL event: got kind %0d cyc %0d val %0d expected kind %0d cyc %0d val %0d",
                     kind, cyc, val, e.kind, e.cyc, e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (cnt_L)  see(0, int'({cnt_up, cnt_di}));
      if (cnt_ce) see(1, int'(cnt_Q));
      if (done)   see(2, int'(pass_cnt));
   end

   function automatic void push_ev(input int k, input int c, input int v);
      ev_t e;
      e.kind = k; e.cyc = c; e.val = v;
      expq.push_back(e);
   endfunction

   // Reference: each pass = 1 load cycle + (N+1) ticks of (d+1) cycles; step k lands on tick k+1
   task automatic push_seq(input int up, input int s, input int en, input int d,
                           input int r, input int base, output int done_at);
      int n, o;
      n = up ? (en - s + MODV) % MODV : (s - en + MODV) % MODV;
      o = base;
      for (int p = 0; p <= r; p++) begin
         push_ev(0, o, (up << W) | s);
         for (int k = 0; k < n; k++)
            push_ev(1, o + (k + 1) * (d + 1), up ? (s + k) % MODV : (s - k + MODV) % MODV);
         o = o + (n + 1) * (d + 1) + 1;
      end
      push_ev(2, o, r + 1);
      done_at = o;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int up, input int s, input int en, input int d, input int r);
      cfg_up    = up[0];
      cfg_start = W'(s);
      cfg_end   = W'(en);
      cfg_div   = DIV_W'(d);
      cfg_reps  = REP_W'(r);
   endtask

   task automatic run_seq(input int up, input int s, input int en, input int d,
                          input int r, input bit scramble);
      int done_at;
      set_cfg(up, s, en, d, r);
      start = 1'b1;
      push_seq(up, s, en, d, r, cyc + 1, done_at);
      step();
      start = 1'b0;
      while (cyc <= done_at + 1) begin
         if (scramble) begin
            cfg_up    = 1'($urandom);
            cfg_start = W'($urandom);
            cfg_end   = W'($urandom);
            cfg_div   = DIV_W'($urandom);
            cfg_reps  = REP_W'($urandom);
         end
         step();
      end
      chk("seq_queue_drained", expq.size(), 0);
      chk("pass_cnt_after", int'(pass_cnt), r + 1);
      chk("busy_after", int'(busy), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_cnt_L"}, int'(cnt_L), 0);
      chk({tag, "_cnt_ce"}, int'(cnt_ce), 0);
      chk({tag, "_cnt_up"}, int'(cnt_up), 0);
      chk({tag, "_cnt_di"}, int'(cnt_di), 0);
      chk({tag, "_pass_cnt"}, int'(pass_cnt), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, done_a, done_b;

      clr = 1'b1;
      step(); step();
      clr = 1'b0;
      chk_all_zero("reset");

      // directed patterns: basic up, down through wrap, repeated zero-length passes
      run_seq(1, 3, 7, 0, 0, 1'b0);
      run_seq(0, 2, 14, 3, 0, 1'b0);
      run_seq(1, 5, 5, 0, 2, 1'b0);

      // abort on the third tick of a 10-step pass
      set_cfg(1, 0, 10, 1, 0);
      start = 1'b1;
      base = cyc + 1;
      push_ev(0, base, (1 << W) | 0);
      push_ev(1, base + 2, 0);
      push_ev(1, base + 4, 1);
      step();
      start = 1'b0;
      while (cyc < base + 6) step();
      abort = 1'b1;
      #1;
      chk("abort_tick_ce", int'(cnt_ce), 0);
      step();
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_pass_cnt", int'(pass_cnt), 0);
      chk("abort_cnt_L", int'(cnt_L), 0);
      repeat (10) step();
      chk("abort_queue_drained", expq.size(), 0);
      run_seq(1, 0, 10, 1, 0, 1'b0);

      // synchronous clear mid-RUN
      set_cfg(1, 1, 9, 2, 1);
      start = 1'b1;
      base = cyc + 1;
      push_ev(0, base, (1 << W) | 1);
      push_ev(1, base + 3, 1);
      step();
      start = 1'b0;
      while (cyc < base + 4) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk_all_zero("clr_mid_run");
      repeat (6) step();
      chk("clr_queue_drained", expq.size(), 0);
      chk("clr_counter_held", int'(cnt_Q), 2);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle_busy", int'(busy), 0);
      chk("start_abort_idle_L", int'(cnt_L), 0);

      // start held through DONE: second sequence begins from IDLE after it
      set_cfg(1, 4, 6, 0, 0);
      start = 1'b1;
      push_seq(1, 4, 6, 0, 0, cyc + 1, done_a);
      while (cyc < done_a + 1) step();
      set_cfg(0, 9, 7, 1, 1);
      push_seq(0, 9, 7, 1, 1, done_a + 2, done_b);
      while (cyc < done_a + 2) step();
      start = 1'b0;
      while (cyc <= done_b + 1) step();
      chk("held_queue_drained", expq.size(), 0);
      chk("held_pass_cnt", int'(pass_cnt), 2);

      // randomized sequences with cfg inputs scrambled while running
      for (int i = 0; i < 8; i++)
         run_seq(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 1'b1);

      chk("final_queue_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
